// File: rtl/mem_byte_sequencer_pkg.sv
// Shared encodings for the byte-wide load/store sequencer: access sizes,
// sequencer FSM states and the size-to-byte-count mapping.
package mem_seq_pkg;

    localparam int WORD_W = 32;

    // Access size encodings as presented on req_size; 2'b11 is reserved
    // and is handled everywhere as a word access.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } seq_state_t;

    // Number of single-byte memory beats needed for an access size.
    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_sequencer_load_extend.sv
// Load result extension: widens the captured low byte or half-word to a
// full word, replicating its MSB for signed loads and zero-filling otherwise.
module mem_load_extend
    import mem_seq_pkg::*;
(
    input  logic [WORD_W-1:0] i_buf,
    input  logic [1:0]        i_size,
    input  logic              i_sign,
    output logic [WORD_W-1:0] o_rdata
);

    logic w_fill_byte;
    logic w_fill_half;

    assign w_fill_byte = i_sign & i_buf[7];
    assign w_fill_half = i_sign & i_buf[15];

    // Select the extension by access size; reserved size falls through to word.
    always_comb begin
        case (i_size)
            SIZE_BYTE: o_rdata = {{(WORD_W-8){w_fill_byte}}, i_buf[7:0]};
            SIZE_HALF: o_rdata = {{(WORD_W-16){w_fill_half}}, i_buf[15:0]};
            default:   o_rdata = i_buf;
        endcase
    end

endmodule

// File: rtl/mem_byte_sequencer.sv
// Load/store sequencer between the memory stage and a byte-wide data memory.
// One request is accepted in IDLE, split into 1/2/4 single-byte beats in XFER
// (one beat per cycle, consecutive wrapping addresses), and answered in RESP
// with the extended load data or a zero completion for stores.
module mem_byte_sequencer
    import mem_seq_pkg::*;
#(
    parameter int NBYTES_MAX = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam int CNT_W = $clog2(NBYTES_MAX);
    localparam int NB_W  = CNT_W + 1;

    seq_state_t        r_state;
    seq_state_t        w_next_state;

    logic [CNT_W-1:0]  r_cnt;
    logic [NB_W-1:0]   r_nbytes;
    logic              r_write;
    logic              r_sign;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_buf;

    logic              w_accept;
    logic              w_last;
    logic [7:0]        w_lane_wdata;
    logic [WORD_W-1:0] w_ext_rdata;

    assign w_accept = req_valid && req_ready;
    assign w_last   = ({1'b0, r_cnt} == (r_nbytes - NB_W'(1)));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and state-decoded handshake/memory outputs. Memory strobes
    // are gated by reset so an aborted access never writes in the reset cycle.
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_rdata    = '0;
        mem_write    = 1'b0;
        mem_read     = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = XFER;
                end
            end
            XFER: begin
                mem_write = r_write && !reset;
                mem_read  = !r_write && !reset;
                mem_addr  = r_addr + ADDR_W'(r_cnt);
                mem_wdata = w_lane_wdata;
                if (w_last) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = r_write ? '0 : w_ext_rdata;
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Store byte-lane mux: pick the byte of the latched store data for this beat.
    always_comb begin
        w_lane_wdata = r_wdata[7:0];
        for (int i = 0; i < NBYTES_MAX; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_lane_wdata = r_wdata[8*i +: 8];
            end
        end
    end

    // Request latch, beat counter and load byte-lane demux into the capture buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_nbytes <= '0;
            r_write  <= 1'b0;
            r_sign   <= 1'b0;
            r_size   <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_buf    <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_nbytes <= NB_W'(size_to_nbytes(req_size));
            r_write  <= req_write;
            r_sign   <= req_sign;
            r_size   <= req_size;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_buf    <= '0;
        end else if (r_state == XFER) begin
            if (!r_write) begin
                for (int i = 0; i < NBYTES_MAX; i++) begin
                    if (r_cnt == CNT_W'(i)) begin
                        r_buf[8*i +: 8] <= mem_rdata;
                    end
                end
            end
            if (!w_last) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    mem_load_extend u_load_extend (
        .i_buf   (r_buf),
        .i_size  (r_size),
        .i_sign  (r_sign),
        .o_rdata (w_ext_rdata)
    );

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Bench for mem_byte_sequencer: a 16-byte data memory (reset contents i+1),
// a transaction-level reference model of that memory, a directed vector
// table, two hand-written corner sequences and a randomized run.
module tb_mem_byte_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_sign = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_byte_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_size  (req_size),
        .req_sign  (req_sign),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Data memory: combinational read, write on the clock edge, wraps mod 16.
    logic [7:0] tmem [16];
    assign mem_rdata = tmem[mem_addr[3:0]];
    always @(posedge clk) begin
        if (mem_rst) begin
            for (int i = 0; i < 16; i++) tmem[i] <= 8'(i + 1);
        end else if (mem_write) begin
            tmem[mem_addr[3:0]] <= mem_wdata;
        end
    end

    // Bus monitor: every memory beat the sequencer issues.
    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [7:0]  wd;
    } beat_t;
    beat_t mq[$];
    always @(negedge clk) begin
        if (mem_write || mem_read) mq.push_back('{mem_write, mem_read, mem_addr, mem_wdata});
    end

    // Reference model: the memory as a plain byte array, accesses as arithmetic.
    logic [7:0] ref_mem [16];

    function automatic int nbytes_of(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model(input bit wr, input logic [1:0] sz, input bit sg,
                                          input logic [31:0] a, input logic [31:0] wd);
        int n;
        int idx;
        longint unsigned v;
        n = nbytes_of(sz);
        v = 0;
        for (int k = 0; k < n; k++) begin
            idx = (int'(a[3:0]) + k) % 16;
            if (wr) ref_mem[idx] = wd[8*k +: 8];
            else    v = v + (longint'(ref_mem[idx]) << (8*k));
        end
        if (wr) return 32'h0;
        if (sg && n < 4 && v >= (64'd1 << (8*n - 1))) v = v + 64'h1_0000_0000 - (64'd1 << (8*n));
        return v[31:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0; mem_rst = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i + 1);
    endtask

    // One complete transaction; called just after a rising edge.
    task automatic run_req(input bit wr, input logic [1:0] sz, input bit sg,
                           input logic [31:0] a, input logic [31:0] wd, input int hold,
                           output logic [31:0] rd, output int lat);
        int guard;
        mq.delete();
        req_write = wr; req_size = sz; req_sign = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        chk("req_ready_wait", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 30);
        rd = rsp_rdata;
        repeat (hold) begin @(posedge clk); #1; end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic chk_trace(input string nm, input bit wr, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = nbytes_of(sz);
        chk({nm, "_beats"}, mq.size(), n);
        for (int k = 0; k < n && k < mq.size(); k++) begin
            chk({nm, "_wr"}, mq[k].wr, wr);
            chk({nm, "_rd"}, mq[k].rd, !wr);
            chk({nm, "_addr"}, mq[k].addr, a + 32'(k));
            if (wr) chk({nm, "_wdata"}, mq[k].wd, wd[8*k +: 8]);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [1:0]  sz;
        bit          sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [31:0] rd;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic [31:0] mres;
        int lat;
        string nm;

        tbl[0]  = '{0, 2'd3, 0, 32'd0,          32'h0,        32'h04030201};
        tbl[1]  = '{0, 2'd1, 0, 32'd14,         32'h0,        32'h0000100F};
        tbl[2]  = '{0, 2'd2, 0, 32'd14,         32'h0,        32'h0201100F};
        tbl[3]  = '{1, 2'd2, 0, 32'd4,          32'hA1B2C3D4, 32'h0};
        tbl[4]  = '{0, 2'd2, 0, 32'd4,          32'h0,        32'hA1B2C3D4};
        tbl[5]  = '{1, 2'd0, 0, 32'd3,          32'h00000080, 32'h0};
        tbl[6]  = '{0, 2'd0, 1, 32'd3,          32'h0,        32'hFFFFFF80};
        tbl[7]  = '{0, 2'd0, 0, 32'd3,          32'h0,        32'h00000080};
        tbl[8]  = '{0, 2'd1, 1, 32'd4,          32'h0,        32'hFFFFC3D4};
        tbl[9]  = '{0, 2'd1, 1, 32'd0,          32'h0,        32'h00000201};
        tbl[10] = '{1, 2'd2, 0, 32'hFFFFFFFE,   32'h11223344, 32'h0};
        tbl[11] = '{0, 2'd2, 0, 32'hFFFFFFFE,   32'h0,        32'h11223344};
        tbl[12] = '{0, 2'd1, 0, 32'hFFFFFFFF,   32'h0,        32'h00002233};
        tbl[13] = '{1, 2'd1, 0, 32'd7,          32'h0000BEEF, 32'h0};
        tbl[14] = '{0, 2'd2, 1, 32'd5,          32'h0,        32'hBEEFB2C3};

        do_reset();
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_read",  mem_read, 0);
        chk("rst_mem_addr",  mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        @(posedge clk); #1;

        // Directed vector table.
        for (int i = 0; i < 15; i++) begin
            nm = $sformatf("vec%0d", i);
            mres = model(tbl[i].wr, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd);
            run_req(tbl[i].wr, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, i % 3, rd, lat);
            chk({nm, "_rdata"}, rd, tbl[i].exp);
            chk({nm, "_lat"}, lat, nbytes_of(tbl[i].sz) + 1);
            chk_trace(nm, tbl[i].wr, tbl[i].sz, tbl[i].a, tbl[i].wd);
        end

        // Response back-pressure with a second request held pending.
        exp1 = model(0, 2'd2, 0, 32'd4, 32'h0);
        exp2 = model(0, 2'd0, 0, 32'd0, 32'h0);
        req_write = 1'b0; req_size = 2'd2; req_sign = 1'b0; req_addr = 32'd4; req_wdata = 32'h0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_size = 2'd0; req_addr = 32'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_ready_xfer", req_ready, 0);
            @(posedge clk); #1;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_rdata", rsp_rdata, exp1);
            chk("bp_ready_resp", req_ready, 0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_rsp_valid_hs", rsp_valid, 1);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_idle_ready", req_ready, 1);
        chk("bp_idle_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("bp_second_ready", req_ready, 0);
        chk("bp_second_read", mem_read, 1);
        chk("bp_second_addr", mem_addr, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_second_valid", rsp_valid, 1);
        chk("bp_second_rdata", rsp_rdata, exp2);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset in the second beat of a word store.
        mq.delete();
        req_write = 1'b1; req_size = 2'd2; req_sign = 1'b0; req_addr = 32'd8; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_beat0_write", mem_write, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_write_gated", mem_write, 0);
        chk("rstmid_read_gated", mem_read, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_req_ready", req_ready, 1);
        chk("rstmid_rsp_valid", rsp_valid, 0);
        chk("rstmid_rsp_rdata", rsp_rdata, 0);
        chk("rstmid_mem_write", mem_write, 0);
        repeat (4) begin @(posedge clk); #1; end
        chk("rstmid_beats", mq.size(), 1);
        if (mq.size() > 0) begin
            chk("rstmid_beat_addr", mq[0].addr, 32'd8);
            chk("rstmid_beat_data", mq[0].wd, 8'h78);
        end
        ref_mem[8] = 8'h78;
        mres = model(0, 2'd0, 0, 32'd8, 32'h0);
        run_req(0, 2'd0, 0, 32'd8, 32'h0, 0, rd, lat);
        chk("rstmid_kept_byte", rd, mres);
        mres = model(0, 2'd0, 0, 32'd9, 32'h0);
        run_req(0, 2'd0, 0, 32'd9, 32'h0, 0, rd, lat);
        chk("rstmid_untouched_byte", rd, mres);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 150; t++) begin
            bit          wr;
            bit          sg;
            logic [1:0]  sz;
            logic [31:0] a;
            logic [31:0] wd;
            wr = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom();
            wd = $urandom();
            nm = $sformatf("rnd%0d", t);
            mres = model(wr, sz, sg, a, wd);
            run_req(wr, sz, sg, a, wd, $urandom_range(0, 2), rd, lat);
            chk({nm, "_rdata"}, rd, mres);
            chk({nm, "_lat"}, lat, nbytes_of(sz) + 1);
            chk_trace(nm, wr, sz, a, wd);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
